// File: rtl/main_memory_block_reader_if.sv
// Block-read bus between the cache (master) and main memory (slave).
// Write port signals exist only when MAIN_MEM_WRITE_EN is defined.
interface main_memory_block_reader_if #(
    parameter int ADDR_WIDTH      = 15,
    parameter int WORDS_PER_BLOCK = 4
);
    localparam int BLK_W  = ADDR_WIDTH - $clog2(WORDS_PER_BLOCK);
    localparam int DATA_W = 32 * WORDS_PER_BLOCK;

    logic              rd_req;
    logic [BLK_W-1:0]  block_addr;
    logic [DATA_W-1:0] block_data;
    logic              block_valid;
    logic              busy;
`ifdef MAIN_MEM_WRITE_EN
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;

    modport master (output rd_req, block_addr, wr_req, wr_addr, wr_data,
                    input  block_data, block_valid, busy);
    modport slave  (input  rd_req, block_addr, wr_req, wr_addr, wr_data,
                    output block_data, block_valid, busy);
`else
    modport master (output rd_req, block_addr,
                    input  block_data, block_valid, busy);
    modport slave  (input  rd_req, block_addr,
                    output block_data, block_valid, busy);
`endif
endinterface

// File: rtl/main_memory_block_reader.sv
// Main-memory backing store: returns one whole block LATENCY cycles after a read request.
// MAIN_MEM_WRITE_EN adds a single-word write port; without it the store is read-only.
//
// state   | meaning
// IDLE    | accepting rd_req (and wr_req when enabled)
// WAIT    | counting down the access latency for the latched block
// DELIVER | block_valid high for one cycle, block_data holds the block
module main_memory_block_reader #(
    parameter int ADDR_WIDTH      = 15,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int LATENCY         = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    main_memory_block_reader_if.slave   bus
);
    localparam int OFS_W  = $clog2(WORDS_PER_BLOCK);
    localparam int BLK_W  = ADDR_WIDTH - OFS_W;
    localparam int DATA_W = 32 * WORDS_PER_BLOCK;
    localparam logic [7:0] LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DELIVER = 2'd2} state_t;

    state_t            state, state_n;
    logic [7:0]        cnt, cnt_n;
    logic [BLK_W-1:0]  addr_q, addr_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic [BLK_W-1:0]  fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              load_data;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [OFS_W-1:0]  word_ofs;

`ifdef MAIN_MEM_WRITE_EN
    logic [31:0] mem [2**ADDR_WIDTH];
    logic        wr_fire;

    assign wr_fire = bus.wr_req && (state == IDLE);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end
`endif

    // Without the write port the array image is the identity map, so a word reads as its own address.
    always_comb begin
        fetch_data = '0;
        word_addr  = '0;
        word_ofs   = '0;
        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
            word_ofs  = OFS_W'(k);
            word_addr = {fetch_addr, word_ofs};
`ifdef MAIN_MEM_WRITE_EN
            // A write at the accepting edge must be visible when LATENCY is 1.
            if (wr_fire && (bus.wr_addr == word_addr)) begin
                fetch_data[32*k +: 32] = bus.wr_data;
            end else begin
                fetch_data[32*k +: 32] = mem[word_addr];
            end
`else
            fetch_data[32*k +: 32] = 32'(word_addr);
`endif
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        addr_n     = addr_q;
        load_data  = 1'b0;
        fetch_addr = addr_q;
        case (state)
            IDLE: begin
                if (bus.rd_req) begin
                    addr_n = bus.block_addr;
                    cnt_n  = LOAD;
                    if (LOAD == 8'd0) begin
                        state_n    = DELIVER;
                        load_data  = 1'b1;
                        fetch_addr = bus.block_addr;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - 8'd1;
                if (cnt <= 8'd1) begin
                    cnt_n     = 8'd0;
                    state_n   = DELIVER;
                    load_data = 1'b1;
                end
            end
            DELIVER: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        data_n = load_data ? fetch_data : data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr_q <= addr_n;
            data_q <= data_n;
        end
    end

    assign bus.block_data  = data_q;
    assign bus.block_valid = (state == DELIVER);
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_main_memory_block_reader.sv
// Scoreboard bench for main_memory_block_reader: directed scenarios plus random traffic.
// Define MAIN_MEM_WRITE_EN to also exercise the write port.
module tb_main_memory_block_reader;
    localparam int LATENCY = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    main_memory_block_reader_if bus_if ();

    main_memory_block_reader #(.ADDR_WIDTH(15), .WORDS_PER_BLOCK(4), .LATENCY(LATENCY)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_if)
    );

    typedef struct {
        int           edge_no;
        logic [127:0] data;
    } exp_t;

    exp_t         exp_q[$];
    int           edge_cnt   = 0;
    int           busy_until = 0;
    int           free_edge  = 0;
    logic [127:0] last_data  = '0;
    int           n_tests    = 0;
    int           n_failed   = 0;

`ifdef MAIN_MEM_WRITE_EN
    bit [31:0] wmem [int];
    initial begin
        for (int i = 0; i < 32768; i++) dut.mem[i] = 32'(i);
    end
`endif

    function automatic logic [31:0] ref_word(input int a);
`ifdef MAIN_MEM_WRITE_EN
        if (wmem.exists(a)) return wmem[a];
`endif
        return 32'(a);
    endfunction

    function automatic logic [127:0] ref_block(input int blk);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = ref_word(blk * 4 + k);
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference model: a request is taken when the block is free; result due LATENCY cycles later.
    always @(posedge clk) begin
        edge_cnt++;
        if (!rst_n) begin
            exp_q.delete();
            busy_until = 0;
            free_edge  = 0;
        end else if (edge_cnt >= free_edge) begin
`ifdef MAIN_MEM_WRITE_EN
            if (bus_if.wr_req) wmem[int'(bus_if.wr_addr)] = bus_if.wr_data;
`endif
            if (bus_if.rd_req) begin
                exp_q.push_back('{edge_cnt + LATENCY - 1, ref_block(int'(bus_if.block_addr))});
                busy_until = edge_cnt + LATENCY - 1;
                free_edge  = edge_cnt + LATENCY + 1;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t it;
        logic exp_v;
        if (!rst_n) begin
            check("rst_busy",  128'(bus_if.busy), 128'(0));
            check("rst_valid", 128'(bus_if.block_valid), 128'(0));
            check("rst_data",  bus_if.block_data, 128'(0));
            last_data = '0;
        end else begin
            check("busy", 128'(bus_if.busy), 128'(edge_cnt <= busy_until));
            exp_v = (exp_q.size() > 0) && (exp_q[0].edge_no == edge_cnt);
            check("valid", 128'(bus_if.block_valid), 128'(exp_v));
            if (exp_v) begin
                it = exp_q.pop_front();
                check("block_data", bus_if.block_data, it.data);
                last_data = it.data;
            end else begin
                check("data_hold", bus_if.block_data, last_data);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string name, input int budget,
                              output logic [127:0] data, output int edge_no);
        data    = '0;
        edge_no = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_if.block_valid) begin
                data    = bus_if.block_data;
                edge_no = edge_cnt;
                break;
            end
        end
        if (edge_no < 0) begin
            n_tests++;
            n_failed++;
            $display("FAIL %s: no block_valid within %0d cycles", name, budget);
        end
        #2;
    endtask

    initial begin
        logic [127:0] d;
        int e1, e2, t_acc;

        bus_if.rd_req     = 1'b0;
        bus_if.block_addr = '0;
`ifdef MAIN_MEM_WRITE_EN
        bus_if.wr_req  = 1'b0;
        bus_if.wr_addr = '0;
        bus_if.wr_data = '0;
`endif
        #1;
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // Single read of block 256
        bus_if.block_addr = 13'd256;
        bus_if.rd_req     = 1'b1;
        t_acc = edge_cnt + 1;
        tick();
        bus_if.rd_req = 1'b0;
        wait_valid("t2_wait", 20, d, e1);
        check("t2_data", d, {32'd1027, 32'd1026, 32'd1025, 32'd1024});
        check("t2_latency", 128'(e1 - t_acc), 128'(LATENCY - 1));
        tick(3);

        // Request while busy is ignored
        bus_if.block_addr = 13'd256;
        bus_if.rd_req     = 1'b1;
        tick();
        bus_if.block_addr = 13'd300;
        tick(4);
        bus_if.rd_req = 1'b0;
        tick(8);

        // Held request re-accepted right after DELIVER
        bus_if.block_addr = 13'd256;
        bus_if.rd_req     = 1'b1;
        tick();
        bus_if.block_addr = 13'd257;
        wait_valid("t4_first", 20, d, e1);
        wait_valid("t4_second", 20, d, e2);
        bus_if.rd_req = 1'b0;
        check("t4_data2", d, {32'd1031, 32'd1030, 32'd1029, 32'd1028});
        check("t4_spacing", 128'(e2 - e1), 128'(LATENCY + 1));
        tick(8);

        // Reset in the middle of a request
        bus_if.block_addr = 13'd10;
        bus_if.rd_req     = 1'b1;
        tick();
        bus_if.rd_req = 1'b0;
        tick(1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        bus_if.rd_req = 1'b1;
        tick();
        bus_if.rd_req = 1'b0;
        wait_valid("t5_wait", 20, d, e1);
        check("t5_data", d, {32'd43, 32'd42, 32'd41, 32'd40});
        tick(3);

`ifdef MAIN_MEM_WRITE_EN
        bus_if.wr_req  = 1'b1;
        bus_if.wr_addr = 15'd1025;
        bus_if.wr_data = 32'hDEADBEEF;
        tick();
        bus_if.wr_req     = 1'b0;
        bus_if.block_addr = 13'd256;
        bus_if.rd_req     = 1'b1;
        tick();
        bus_if.rd_req = 1'b0;
        wait_valid("t6_wait", 20, d, e1);
        check("t6_data", d, {32'd1027, 32'd1026, 32'hDEADBEEF, 32'd1024});
        tick(2);
        bus_if.wr_req  = 1'b1;
        bus_if.wr_addr = 15'd1026;
        bus_if.wr_data = 32'hCAFEF00D;
        bus_if.rd_req  = 1'b1;
        tick();
        bus_if.wr_req = 1'b0;
        bus_if.rd_req = 1'b0;
        wait_valid("t6_same_edge", 20, d, e1);
        check("t6_data2", d, {32'd1027, 32'hCAFEF00D, 32'hDEADBEEF, 32'd1024});
        tick(2);
`endif

        // Random traffic, occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                bus_if.rd_req = 1'b0;
                rst_n = 1'b0;
                tick($urandom_range(1, 2));
                rst_n = 1'b1;
            end
            bus_if.rd_req = ($urandom_range(0, 2) == 0);
`ifdef MAIN_MEM_WRITE_EN
            bus_if.block_addr = 13'($urandom_range(256, 275));
            bus_if.wr_req     = ($urandom_range(0, 3) == 0);
            bus_if.wr_addr    = 15'($urandom_range(1024, 1103));
            bus_if.wr_data    = $urandom;
`else
            bus_if.block_addr = 13'($urandom_range(0, 8191));
`endif
            tick();
        end
        bus_if.rd_req = 1'b0;
`ifdef MAIN_MEM_WRITE_EN
        bus_if.wr_req = 1'b0;
`endif

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
        check("drain_empty", 128'(exp_q.size()), 128'(0));
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
